// File: rtl/sha256_pkg.sv
// Shared constants and types for the SHA-256 nonce scheduler.
// Padding words close a single 80-byte block header; the inflight counter covers a 66-deep pipeline.
package sha256_pkg;

  localparam logic [31:0] PAD_ONE    = 32'h80000000;
  localparam logic [31:0] PAD_LEN    = 32'h00000280;
  localparam int          INFLIGHT_W = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } sched_state_e;

  // Second header chunk: tail words 0..2, nonce, then fixed padding and bit length.
  function automatic logic [511:0] build_chunk(input logic [95:0] tail,
                                               input logic [31:0] nonce);
    return {tail, nonce, PAD_ONE, 320'd0, PAD_LEN};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with a combinational read port.
// A push into a full FIFO succeeds when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic [AW-1:0]               rd_q, wr_q;
  logic [AW:0]                 cnt_q;
  logic                        wr_en, rd_en;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign wr_en   = push_i && (!full_o || pop_i);
  assign rd_en   = pop_i && !empty_o;
  assign dout_o  = mem_q[rd_q];

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == AW'(DEPTH-1)) ? '0 : p + AW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_q] <= din_i;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (wr_en) wr_q <= nxt(wr_q);
      if (rd_en) rd_q <= nxt(rd_q);
      case ({wr_en, rd_en})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/sha256_nonce_sched.sv
// Issues one nonce per cycle into a SHA-256 pipeline and collects hits from its results.
// Completion is tracked purely by an inflight count, so pipeline latency never matters here.
module sha256_nonce_sched
  import sha256_pkg::*;
(
  input  logic         clk,
  input  logic         arst_n,
  input  logic         job_we,
  input  logic [255:0] midstate_i,
  input  logic [95:0]  tail_i,
  input  logic [31:0]  target_i,
  input  logic [31:0]  nonce_first_i,
  input  logic [31:0]  nonce_last_i,
  input  logic         start,
  input  logic         abort,
  output logic         ppl_valid_i,
  output logic [255:0] ppl_init,
  output logic [511:0] ppl_chunk,
  input  logic         ppl_valid_o,
  input  logic [255:0] ppl_hash,
  output logic         busy,
  output logic         done,
  output logic         hit_valid,
  input  logic         hit_ready,
  output logic [31:0]  hit_nonce,
  output logic         hit_overflow
);

  sched_state_e          state_q, state_d;
  logic [255:0]          mid_q;
  logic [95:0]           tail_q;
  logic [31:0]           target_q, first_q, last_q;
  logic [31:0]           issue_q, ret_q;
  logic [INFLIGHT_W-1:0] inflight_q;
  logic                  ovf_q;

  logic issue, start_acc, res_ok, hit;
  logic fifo_pop, fifo_empty, fifo_full;
  logic unused_hash;

  always_comb begin
    state_d   = state_q;
    issue     = 1'b0;
    start_acc = 1'b0;
    done      = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d   = RUN;
        start_acc = 1'b1;
      end
      RUN: begin
        if (abort) state_d = DRAIN;
        else begin
          issue = 1'b1;
          if (issue_q == last_q) state_d = DRAIN;
        end
      end
      DRAIN: if (inflight_q == '0) begin
        state_d = IDLE;
        done    = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Results are in order; a result with nothing outstanding is spurious and dropped.
  assign res_ok      = ppl_valid_o && (inflight_q != '0);
  assign hit         = res_ok && (ppl_hash[31:0] <= target_q);
  assign fifo_pop    = hit_valid && hit_ready;
  assign unused_hash = ^ppl_hash[255:32];

  assign ppl_valid_i  = issue;
  assign ppl_init     = mid_q;
  assign ppl_chunk    = build_chunk(tail_q, issue_q);
  assign busy         = (state_q != IDLE);
  assign hit_valid    = !fifo_empty;
  assign hit_overflow = ovf_q;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q    <= IDLE;
      mid_q      <= '0;
      tail_q     <= '0;
      target_q   <= '0;
      first_q    <= '0;
      last_q     <= '0;
      issue_q    <= '0;
      ret_q      <= '0;
      inflight_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (job_we && state_q == IDLE) begin
        mid_q    <= midstate_i;
        tail_q   <= tail_i;
        target_q <= target_i;
        first_q  <= nonce_first_i;
        last_q   <= nonce_last_i;
      end
      if (start_acc)  issue_q <= first_q;
      else if (issue) issue_q <= issue_q + 32'd1;
      if (start_acc)   ret_q <= first_q;
      else if (res_ok) ret_q <= ret_q + 32'd1;
      case ({issue, res_ok})
        2'b10:   inflight_q <= inflight_q + INFLIGHT_W'(1);
        2'b01:   inflight_q <= inflight_q - INFLIGHT_W'(1);
        default: inflight_q <= inflight_q;
      endcase
      if (start_acc)                           ovf_q <= 1'b0;
      else if (hit && fifo_full && !fifo_pop)  ovf_q <= 1'b1;
    end
  end

  sync_fifo #(.WIDTH(32), .DEPTH(4)) u_hit_fifo (
    .clk     (clk),
    .arst_n  (arst_n),
    .push_i  (hit),
    .din_i   (ret_q),
    .pop_i   (fifo_pop),
    .dout_o  (hit_nonce),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

endmodule

// File: tb/tb_sha256_nonce_sched.sv
// Directed and randomized bench for sha256_nonce_sched with a fixed-latency pipeline model
// and a reference model of issued nonces, expected hits and the 4-deep hit queue.
module tb_sha256_nonce_sched;

  logic         clk = 1'b0;
  logic         arst_n;
  logic         job_we, start, abort, ppl_valid_o, hit_ready;
  logic [255:0] midstate_i, ppl_hash;
  logic [95:0]  tail_i;
  logic [31:0]  target_i, nonce_first_i, nonce_last_i;
  logic         ppl_valid_i, busy, done, hit_valid, hit_overflow;
  logic [255:0] ppl_init;
  logic [511:0] ppl_chunk;
  logic [31:0]  hit_nonce;

  always #5 clk = ~clk;

  sha256_nonce_sched dut (
    .clk(clk), .arst_n(arst_n), .job_we(job_we), .midstate_i(midstate_i),
    .tail_i(tail_i), .target_i(target_i), .nonce_first_i(nonce_first_i),
    .nonce_last_i(nonce_last_i), .start(start), .abort(abort),
    .ppl_valid_i(ppl_valid_i), .ppl_init(ppl_init), .ppl_chunk(ppl_chunk),
    .ppl_valid_o(ppl_valid_o), .ppl_hash(ppl_hash), .busy(busy), .done(done),
    .hit_valid(hit_valid), .hit_ready(hit_ready), .hit_nonce(hit_nonce),
    .hit_overflow(hit_overflow)
  );

  typedef struct { logic [31:0] n; int due; } pend_t;

  pend_t        pq[$];
  logic [31:0]  exp_q[$];
  int           checks = 0, errors = 0;
  int           cyc_n = 0, lat = 66, rdy_mode = 1;
  int           issued, outstanding = 0, last_ret, done_cyc, pops = 0;
  bit           done_seen, spur = 1'b0, m_ovf = 1'b0;
  logic [31:0]  salt, m_target, exp_next;
  logic [255:0] m_mid;
  logic [95:0]  m_tail;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] hw7(input logic [31:0] n);
    return (n * 32'h9E3779B1) ^ salt;
  endfunction

  // One clock cycle: deliver due results, sample at negedge, update the reference model.
  task automatic cyc();
    pend_t        p;
    logic [31:0]  rn;
    logic [255:0] h;
    bit           got;
    got = 1'b0;
    rn = '0;
    ppl_valid_o = 1'b0;
    ppl_hash = '0;
    if (spur) begin
      ppl_valid_o = 1'b1;
    end else if (pq.size() > 0 && pq[0].due <= cyc_n) begin
      p = pq.pop_front();
      rn = p.n;
      got = 1'b1;
      for (int i = 1; i < 8; i++) h[i*32 +: 32] = $urandom;
      h[31:0] = hw7(rn);
      ppl_hash = h;
      ppl_valid_o = 1'b1;
    end
    if (rdy_mode == 2) hit_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    chk("overflow", hit_overflow, m_ovf);
    chk("hit_valid", hit_valid, exp_q.size() != 0);
    if (hit_valid && hit_ready && exp_q.size() != 0) begin
      chk("hit_nonce", hit_nonce, exp_q[0]);
      void'(exp_q.pop_front());
      pops++;
    end
    if (ppl_valid_i) begin
      chk("issue_nonce", ppl_chunk[415:384], exp_next);
      chk("chunk_tail", ppl_chunk[511:416] == m_tail && ppl_init == m_mid, 1);
      chk("chunk_pad", ppl_chunk[383:352] == 32'h80000000 && ppl_chunk[351:32] == '0
                       && ppl_chunk[31:0] == 32'h00000280, 1);
      pq.push_back('{ppl_chunk[415:384], cyc_n + lat});
      exp_next = exp_next + 32'd1;
      issued++;
      outstanding++;
    end
    if (got) begin
      outstanding--;
      last_ret = cyc_n;
      if (hw7(rn) <= m_target) begin
        if (exp_q.size() < 4) exp_q.push_back(rn);
        else m_ovf = 1'b1;
      end
    end
    if (done) begin
      chk("done_outstanding", outstanding, 0);
      done_seen = 1'b1;
      done_cyc = cyc_n;
    end
    @(posedge clk);
    #1;
    cyc_n++;
    start = 1'b0;
    abort = 1'b0;
    job_we = 1'b0;
    spur = 1'b0;
  endtask

  task automatic load(input logic [31:0] f, l, t);
    for (int i = 0; i < 8; i++) midstate_i[i*32 +: 32] = $urandom;
    for (int i = 0; i < 3; i++) tail_i[i*32 +: 32] = $urandom;
    target_i = t;
    nonce_first_i = f;
    nonce_last_i = l;
    job_we = 1'b1;
    m_mid = midstate_i;
    m_tail = tail_i;
    m_target = t;
    exp_next = f;
    issued = 0;
    done_seen = 1'b0;
    cyc();
  endtask

  // ab/pk: loop index for abort / job_we+start poke (index 0 is the start cycle).
  task automatic go(input logic [31:0] f, l, t, input int L, ab, pk, rm, nexp);
    int p0;
    lat = L;
    rdy_mode = rm;
    hit_ready = (rm != 0);
    load(f, l, t);
    for (int k = 0; k < 400 && !done_seen; k++) begin
      if (k == 0) start = 1'b1;
      if (k == ab) abort = 1'b1;
      if (k == pk) begin
        job_we = 1'b1;
        start = 1'b1;
        midstate_i = ~midstate_i;
        nonce_first_i = $urandom;
      end
      cyc();
      if (k == 0) m_ovf = 1'b0;
    end
    chk("issued", issued, nexp);
    chk("done_seen", done_seen, 1);
    if (issued > 0) chk("done_lat", done_cyc, last_ret + 1);
    chk("busy_after", busy, 0);
    p0 = pops;
    if (rm == 0) begin
      chk("ovf_hold", hit_overflow, 1);
      chk("fifo_head", hit_nonce, f);
    end
    rdy_mode = 1;
    hit_ready = 1'b1;
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) cyc();
    if (rm == 0) chk("drain4", pops - p0, 4);
    cyc();
    chk("hit_empty", hit_valid, 0);
  endtask

  initial begin
    arst_n = 1'b0;
    job_we = 1'b0; start = 1'b0; abort = 1'b0; ppl_valid_o = 1'b0; hit_ready = 1'b1;
    midstate_i = '0; tail_i = '0; target_i = '0; nonce_first_i = '0; nonce_last_i = '0;
    ppl_hash = '0;
    salt = $urandom | 32'h1;
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", ppl_valid_i, 0);
    chk("rst_hit", hit_valid, 0);
    chk("rst_ovf", hit_overflow, 0);
    chk("rst_init", ppl_init, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    arst_n = 1'b1;
    @(posedge clk);
    #1;

    go(32'h10, 32'h13, 32'h0, 66, -1, -1, 1, 4);
    go(32'hFFFFFFFE, 32'h1, $urandom, 5, -1, -1, 2, 4);
    go(32'h20, 32'h27, 32'hFFFFFFFF, 10, -1, -1, 0, 8);
    go(32'd1000, 32'd1099, 32'hFFFFFFFF, 20, 3, -1, 1, 2);
    go(32'hABCD, 32'hABCD, 32'hFFFFFFFF, 66, -1, -1, 1, 1);
    go(32'h500, 32'h50F, $urandom, 7, 0, -1, 1, 16);
    go(32'h600, 32'h61F, $urandom, 12, -1, 5, 2, 32);

    // Spurious results with nothing outstanding must be ignored.
    m_target = 32'hFFFFFFFF;
    spur = 1'b1; cyc();
    spur = 1'b1; cyc();
    chk("spur_busy", busy, 0);
    go(32'h700, 32'h702, 32'hFFFFFFFF, 3, -1, -1, 1, 3);

    // Asynchronous reset in the middle of a run.
    lat = 66;
    rdy_mode = 1;
    hit_ready = 1'b1;
    load(32'h0, 32'd99, 32'hFFFFFFFF);
    start = 1'b1;
    cyc();
    m_ovf = 1'b0;
    repeat (30) cyc();
    chk("pre_rst_issued", issued, 30);
    arst_n = 1'b0;
    #1;
    chk("mrst_valid", ppl_valid_i, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    chk("mrst_hit", hit_valid, 0);
    chk("mrst_ovf", hit_overflow, 0);
    pq.delete();
    exp_q.delete();
    outstanding = 0;
    m_ovf = 1'b0;
    @(negedge clk);
    arst_n = 1'b1;
    @(posedge clk);
    #1;
    go(32'h40, 32'h49, 32'h80000000, 66, -1, -1, 2, 10);

    for (int j = 0; j < 6; j++) begin
      logic [31:0] f;
      int          len;
      f = $urandom;
      len = $urandom_range(1, 40);
      salt = $urandom;
      go(f, f + 32'(len) - 32'd1, $urandom, $urandom_range(1, 70), -1, -1, 2, len);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
